// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers decode outputs, forwards EX/MEM and
// MEM/WB results into the ALU operands, and raises load-use holds.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      alu_src_i,
  input  logic [2:0]                alu_ctrl_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     exmem_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                      memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     memwb_result_i,
  output logic [DATA_WIDTH-1:0]     ALUop1,
  output logic [DATA_WIDTH-1:0]     ALUop2,
  output logic [2:0]                ALUctrl,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      valid_o,
  output logic                      hazard_o
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0]     rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs1a_q, rs1a_d;
  logic [REG_ADDR_WIDTH-1:0] rs2a_q, rs2a_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      alu_src_q, alu_src_d;
  logic [2:0]                ctrl_q, ctrl_d;
  logic                      regw_q, regw_d;
  logic                      memrd_q, memrd_d;

  logic                      bubble;
  logic                      capture;
  logic [DATA_WIDTH-1:0]     fwd1;
  logic [DATA_WIDTH-1:0]     fwd2;

  assign hazard_o = !stall_i && valid_i && valid_q && memrd_q
                 && (rd_q != '0)
                 && ((rd_q == rs1_addr_i) || (rd_q == rs2_addr_i));

  assign bubble  = flush_i || (!stall_i && hazard_o);
  assign capture = !flush_i && !stall_i && !hazard_o;

  always_comb begin
    valid_d   = valid_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rs1a_d    = rs1a_q;
    rs2a_d    = rs2a_q;
    rd_d      = rd_q;
    alu_src_d = alu_src_q;
    ctrl_d    = ctrl_q;
    regw_d    = regw_q;
    memrd_d   = memrd_q;
    unique case (1'b1)
      bubble: begin
        valid_d   = 1'b0;
        rs1_d     = '0;
        rs2_d     = '0;
        imm_d     = '0;
        rs1a_d    = '0;
        rs2a_d    = '0;
        rd_d      = '0;
        alu_src_d = 1'b0;
        ctrl_d    = '0;
        regw_d    = 1'b0;
        memrd_d   = 1'b0;
      end
      capture: begin
        valid_d   = valid_i;
        rs1_d     = rs1_data_i;
        rs2_d     = rs2_data_i;
        imm_d     = imm_i;
        rs1a_d    = rs1_addr_i;
        rs2a_d    = rs2_addr_i;
        rd_d      = rd_addr_i;
        alu_src_d = alu_src_i;
        ctrl_d    = alu_ctrl_i;
        regw_d    = reg_write_i && valid_i;
        memrd_d   = mem_read_i && valid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rs1a_q    <= '0;
      rs2a_q    <= '0;
      rd_q      <= '0;
      alu_src_q <= 1'b0;
      ctrl_q    <= '0;
      regw_q    <= 1'b0;
      memrd_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      rs1a_q    <= rs1a_d;
      rs2a_q    <= rs2a_d;
      rd_q      <= rd_d;
      alu_src_q <= alu_src_d;
      ctrl_q    <= ctrl_d;
      regw_q    <= regw_d;
      memrd_q   <= memrd_d;
    end
  end

  // EX/MEM is the younger producer, so it is checked first
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0]     d
  );
    if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == a)
      return exmem_result_i;
    else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == a)
      return memwb_result_i;
    else
      return d;
  endfunction

  assign fwd1 = fwd(rs1a_q, rs1_q);
  assign fwd2 = fwd(rs2a_q, rs2_q);

  assign ALUop1       = fwd1;
  assign ALUop2       = alu_src_q ? imm_q : fwd2;
  assign store_data_o = fwd2;
  assign ALUctrl      = ctrl_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = regw_q;
  assign mem_read_o   = memrd_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, forwarding,
// load-use bubble, flush/stall priority and async reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        alu_src_i;
  logic [2:0]  alu_ctrl_i;
  logic        reg_write_i, mem_read_i, stall_i, flush_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic [31:0] ALUop1, ALUop2, store_data_o;
  logic [2:0]  ALUctrl;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, valid_o, hazard_o;

  int checks = 0;
  int failures = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .alu_src_i(alu_src_i),
    .alu_ctrl_i(alu_ctrl_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .stall_i(stall_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_result_i(memwb_result_i),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .valid_o(valid_o), .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic dec(input logic [4:0] a1, input logic [31:0] d1,
                     input logic [4:0] a2, input logic [31:0] d2,
                     input logic [4:0] rd, input logic [2:0] ctl,
                     input logic ld);
    valid_i     = 1'b1;
    rs1_addr_i  = a1;
    rs1_data_i  = d1;
    rs2_addr_i  = a2;
    rs2_data_i  = d2;
    rd_addr_i   = rd;
    alu_ctrl_i  = ctl;
    mem_read_i  = ld;
    reg_write_i = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 0; rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
    alu_src_i = 0; alu_ctrl_i = 0; reg_write_i = 0; mem_read_i = 0;
    stall_i = 0; flush_i = 0;
    exmem_rd_i = 0; exmem_reg_write_i = 0; exmem_result_i = 0;
    memwb_rd_i = 0; memwb_reg_write_i = 0; memwb_result_i = 0;
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_regw", reg_write_o, 0);
    chk("rst_memrd", mem_read_o, 0);
    chk("rst_ctrl", ALUctrl, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_haz", hazard_o, 0);
    chk("rst_op1", ALUop1, 0);
    chk("rst_op2", ALUop2, 0);
    step();
    rst_n = 1'b1;

    // plain capture, SUB
    dec(5'd1, 32'd7, 5'd2, 32'd5, 5'd6, 3'd1, 1'b0);
    step();
    chk("cap_op1", ALUop1, 7);
    chk("cap_op2", ALUop2, 5);
    chk("cap_ctrl", ALUctrl, 1);
    chk("cap_valid", valid_o, 1);
    chk("cap_regw", reg_write_o, 1);
    chk("cap_rd", rd_addr_o, 6);

    alu_src_i = 1'b1;
    imm_i     = 32'hFFFF_FFFC;
    step();
    chk("imm_op2", ALUop2, 32'hFFFF_FFFC);
    chk("imm_st", store_data_o, 5);
    alu_src_i = 1'b0;

    // forwarding priority on both sources
    dec(5'd3, 32'd7, 5'd3, 32'd5, 5'd6, 3'd0, 1'b0);
    step();
    exmem_rd_i = 5'd3; exmem_reg_write_i = 1; exmem_result_i = 32'h11;
    memwb_rd_i = 5'd3; memwb_reg_write_i = 1; memwb_result_i = 32'h22;
    #1;
    chk("fw_ex_op1", ALUop1, 32'h11);
    chk("fw_ex_st", store_data_o, 32'h11);
    exmem_reg_write_i = 0;
    #1;
    chk("fw_wb_op1", ALUop1, 32'h22);
    chk("fw_wb_st", store_data_o, 32'h22);
    exmem_reg_write_i = 1;
    exmem_rd_i = 0; memwb_rd_i = 0;
    #1;
    chk("fw_x0_op1", ALUop1, 7);
    chk("fw_x0_st", store_data_o, 5);
    exmem_reg_write_i = 0; memwb_reg_write_i = 0;

    // load-use: load x4, then consumer of x4 on rs2
    dec(5'd1, 32'd1, 5'd2, 32'd2, 5'd4, 3'd0, 1'b1);
    step();
    chk("ld_memrd", mem_read_o, 1);
    dec(5'd1, 32'd10, 5'd4, 32'd9, 5'd5, 3'd2, 1'b0);
    #1;
    chk("lu_haz", hazard_o, 1);
    step();
    chk("lu_bub_valid", valid_o, 0);
    chk("lu_bub_regw", reg_write_o, 0);
    chk("lu_bub_ctrl", ALUctrl, 0);
    chk("lu_haz_clr", hazard_o, 0);
    step();
    memwb_rd_i = 5'd4; memwb_reg_write_i = 1; memwb_result_i = 32'h44;
    #1;
    chk("lu_fw_op2", ALUop2, 32'h44);
    chk("lu_valid", valid_o, 1);
    chk("lu_ctrl", ALUctrl, 2);
    memwb_reg_write_i = 0;

    // flush beats stall
    flush_i = 1; stall_i = 1;
    step();
    flush_i = 0; stall_i = 0;
    chk("fl_valid", valid_o, 0);
    chk("fl_ctrl", ALUctrl, 0);
    chk("fl_op1", ALUop1, 0);

    // stall holds everything and masks the load-use request
    dec(5'd1, 32'hAA, 5'd2, 32'hBB, 5'd4, 3'd3, 1'b1);
    step();
    stall_i = 1;
    dec(5'd4, 32'h55, 5'd2, 32'h66, 5'd7, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_haz", hazard_o, 0);
      step();
      chk("st_valid", valid_o, 1);
      chk("st_ctrl", ALUctrl, 3);
      chk("st_op1", ALUop1, 32'hAA);
      chk("st_rd", rd_addr_o, 4);
      chk("st_memrd", mem_read_o, 1);
    end
    stall_i = 0;
    #1;
    chk("st_rel_haz", hazard_o, 1);

    // asynchronous reset mid-cycle over a valid ADD
    dec(5'd1, 32'h33, 5'd2, 32'h44, 5'd9, 3'd0, 1'b0);
    step();
    step();
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_op1", ALUop1, 32'h33);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_regw", reg_write_o, 0);
    chk("arst_rd", rd_addr_o, 0);
    chk("arst_op1", ALUop1, 0);
    chk("arst_st", store_data_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
